// File: rtl/symbol_deser_pkg.sv
// Shared types and sizing helpers for the start/stop-framed symbol deserializer.
package symbol_deser_pkg;

   // Receive FSM states. WAIT_IDLE parks the receiver after a bad stop bit.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA      = 2'd1,
      STOP      = 2'd2,
      WAIT_IDLE = 2'd3
   } deser_state_t;

   // Width of a counter that must be able to hold the value max_count.
   function automatic int cnt_width(input int max_count);
      if (max_count < 1) begin
         return 1;
      end
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/symbol_deserializer.sv
// Recovers start/stop-framed symbols from a qualified serial bit stream and
// presents each good payload as a parallel word with a one-cycle valid strobe.
// Bad stop bits raise a one-cycle framing_error pulse, bump a saturating error
// counter and park the receiver until the line returns to the idle level.
module symbol_deserializer
   import symbol_deser_pkg::*;
#(
   parameter int   DATA_WIDTH    = 8,
   parameter int   STOP_BITS     = 1,
   parameter logic START_LEVEL   = 1'b0,
   parameter int   MSB_FIRST     = 0,
   parameter int   ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_bit,
   input  logic                     in_valid,
   input  logic                     err_clr,
   output logic [DATA_WIDTH-1:0]    parallel_data,
   output logic                     data_valid,
   output logic                     framing_error,
   output logic                     busy,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam int BIT_CW  = cnt_width(DATA_WIDTH);
   localparam int STOP_CW = cnt_width(STOP_BITS);

   localparam logic [BIT_CW-1:0]  LAST_BIT   = BIT_CW'(DATA_WIDTH - 1);
   localparam logic [STOP_CW-1:0] LAST_STOP  = STOP_CW'(STOP_BITS - 1);
   localparam logic               IDLE_LEVEL = ~START_LEVEL;

   deser_state_t           state;
   deser_state_t           state_next;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic [DATA_WIDTH-1:0]  shift_next;
   logic [BIT_CW-1:0]      bit_cnt;
   logic [BIT_CW-1:0]      bit_cnt_next;
   logic [STOP_CW-1:0]     stop_cnt;
   logic [STOP_CW-1:0]     stop_cnt_next;
   logic                   symbol_done;
   logic                   stop_error;

   // Next-state, shift and counter updates; nothing moves unless in_valid is high.
   always_comb begin
      state_next    = state;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt;
      stop_cnt_next = stop_cnt;
      symbol_done   = 1'b0;
      stop_error    = 1'b0;

      if (in_valid) begin
         case (state)
            IDLE: begin
               if (in_bit == START_LEVEL) begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end
            end

            DATA: begin
               if (MSB_FIRST != 0) begin
                  shift_next = {shift_reg[DATA_WIDTH-2:0], in_bit};
               end else begin
                  shift_next = {in_bit, shift_reg[DATA_WIDTH-1:1]};
               end
               bit_cnt_next = bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_next    = STOP;
                  stop_cnt_next = '0;
               end
            end

            STOP: begin
               if (in_bit == IDLE_LEVEL) begin
                  if (stop_cnt == LAST_STOP) begin
                     symbol_done = 1'b1;
                     state_next  = IDLE;
                  end else begin
                     stop_cnt_next = stop_cnt + 1'b1;
                  end
               end else begin
                  stop_error = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end

            WAIT_IDLE: begin
               if (in_bit == IDLE_LEVEL) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State, shift register and registered output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         stop_cnt      <= '0;
         parallel_data <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_next;
         shift_reg     <= shift_next;
         bit_cnt       <= bit_cnt_next;
         stop_cnt      <= stop_cnt_next;
         data_valid    <= symbol_done;
         framing_error <= stop_error;
         if (symbol_done) begin
            parallel_data <= shift_reg;
         end
      end
   end

   // Saturating framing-error counter; a clear beats a coincident new error.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (stop_error && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_symbol_deserializer.sv
// Self-checking bench for symbol_deserializer. Three instances share one
// serial input: the default LSB-first build, an MSB-first build and a build
// with a 2-bit error counter. Expected values come from a frame-level model.
module tb_symbol_deserializer;

   logic       clk;
   logic       rst;
   logic       in_bit;
   logic       in_valid;
   logic       err_clr;

   logic [7:0] pd;
   logic       dv;
   logic       fe;
   logic       busy;
   logic [7:0] ec;

   logic [7:0] pd_m;
   logic       dv_m;
   logic       fe_m;
   logic       busy_m;
   logic [7:0] ec_m;

   logic [7:0] pd_s;
   logic       dv_s;
   logic       fe_s;
   logic       busy_s;
   logic [1:0] ec_s;

   int         total = 0;
   int         bad = 0;

   logic [7:0] lsb_q[$];
   logic [7:0] msb_q[$];
   int         dv_cnt = 0;
   int         fe_cnt = 0;

   int         model_errs = 0;
   logic [7:0] last_good = 8'h00;

   symbol_deserializer #(
      .DATA_WIDTH(8), .STOP_BITS(1), .START_LEVEL(1'b0), .MSB_FIRST(0), .ERR_CNT_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .err_clr(err_clr),
      .parallel_data(pd), .data_valid(dv), .framing_error(fe), .busy(busy), .err_count(ec)
   );

   symbol_deserializer #(
      .DATA_WIDTH(8), .STOP_BITS(1), .START_LEVEL(1'b0), .MSB_FIRST(1), .ERR_CNT_WIDTH(8)
   ) dut_msb (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .err_clr(err_clr),
      .parallel_data(pd_m), .data_valid(dv_m), .framing_error(fe_m), .busy(busy_m), .err_count(ec_m)
   );

   symbol_deserializer #(
      .DATA_WIDTH(8), .STOP_BITS(1), .START_LEVEL(1'b0), .MSB_FIRST(0), .ERR_CNT_WIDTH(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .err_clr(err_clr),
      .parallel_data(pd_s), .data_valid(dv_s), .framing_error(fe_s), .busy(busy_s), .err_count(ec_s)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect delivered symbols and error pulses mid-cycle, away from the edge.
   always @(negedge clk) begin
      if (dv) begin
         lsb_q.push_back(pd);
         dv_cnt++;
      end
      if (dv_m) begin
         msb_q.push_back(pd_m);
      end
      if (fe) begin
         fe_cnt++;
      end
   end

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = v[7-i];
      end
      return r;
   endfunction

   function automatic int sat(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      in_bit   = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      step();
   endtask

   task automatic gap(input int gap_mode);
      if (gap_mode == 1) begin
         idle_cycle();
      end else if (gap_mode == 2) begin
         repeat ($urandom_range(0, 2)) idle_cycle();
      end
   endtask

   // Start bit, payload on the wire in order d[0]..d[7], one stop bit.
   task automatic send_frame(input logic [7:0] d, input logic good_stop,
                             input int gap_mode, input logic clr_on_stop);
      gap(gap_mode);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         gap(gap_mode);
         send_bit(d[i]);
      end
      gap(gap_mode);
      err_clr = clr_on_stop;
      send_bit(good_stop);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b1;
      err_clr  = 1'b0;
      repeat (3) step();
      total++; if (pd !== 8'h00) begin bad++; $display("[TB] FAIL reset_pd: got %h want 00", pd); end
      total++; if (dv !== 1'b0) begin bad++; $display("[TB] FAIL reset_dv: got %b want 0", dv); end
      total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL reset_fe: got %b want 0", fe); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (ec !== 8'd0) begin bad++; $display("[TB] FAIL reset_ec: got %0d want 0", ec); end
      rst = 1'b0;
      step();
      model_errs = 0;
      last_good  = 8'h00;
   endtask

   task automatic test_basic();
      logic [9:0] bits;
      int         dv_before;
      bits      = 10'b1101001010;
      dv_before = dv_cnt;
      for (int i = 0; i < 10; i++) begin
         send_bit(bits[i]);
         if (i < 9) begin
            total++; if (dv !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_dv bit %0d: got %b want 0", i, dv); end
         end
      end
      total++; if (dv !== 1'b1) begin bad++; $display("[TB] FAIL basic_dv: got %b want 1", dv); end
      total++; if (pd !== 8'hA5) begin bad++; $display("[TB] FAIL basic_pd: got %h want a5", pd); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy: got %b want 0", busy); end
      idle_cycle();
      total++; if (dv !== 1'b0) begin bad++; $display("[TB] FAIL basic_dv_pulse: got %b want 0", dv); end
      total++; if (dv_cnt - dv_before !== 1) begin bad++; $display("[TB] FAIL basic_pulses: got %0d want 1", dv_cnt - dv_before); end
      last_good = 8'hA5;
   endtask

   task automatic test_gapped();
      int dv_before;
      dv_before = dv_cnt;
      send_frame(8'hA5, 1'b1, 1, 1'b0);
      total++; if (dv !== 1'b1) begin bad++; $display("[TB] FAIL gapped_dv: got %b want 1", dv); end
      total++; if (pd !== 8'hA5) begin bad++; $display("[TB] FAIL gapped_pd: got %h want a5", pd); end
      idle_cycle();
      idle_cycle();
      total++; if (dv_cnt - dv_before !== 1) begin bad++; $display("[TB] FAIL gapped_pulses: got %0d want 1", dv_cnt - dv_before); end
      last_good = 8'hA5;
   endtask

   task automatic test_back_to_back();
      logic [7:0] syms[3];
      syms = '{8'h3C, 8'hC3, 8'h01};
      lsb_q.delete();
      msb_q.delete();
      for (int k = 0; k < 3; k++) begin
         send_frame(syms[k], 1'b1, 0, 1'b0);
         total++; if (dv !== 1'b1) begin bad++; $display("[TB] FAIL b2b_dv sym %0d: got %b want 1", k, dv); end
      end
      idle_cycle();
      total++; if (lsb_q.size() !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", lsb_q.size()); end
      for (int k = 0; k < 3; k++) begin
         if (lsb_q.size() > 0) begin
            logic [7:0] got;
            got = lsb_q.pop_front();
            total++; if (got !== syms[k]) begin bad++; $display("[TB] FAIL b2b_lsb sym %0d: got %h want %h", k, got, syms[k]); end
         end
         if (msb_q.size() > 0) begin
            logic [7:0] got;
            got = msb_q.pop_front();
            total++; if (got !== rev8(syms[k])) begin bad++; $display("[TB] FAIL b2b_msb sym %0d: got %h want %h", k, got, rev8(syms[k])); end
         end
      end
      last_good = 8'h01;
   endtask

   task automatic test_framing();
      int fe_before;
      int dv_before;
      int busy_low;
      fe_before = fe_cnt;
      dv_before = dv_cnt;
      send_frame(8'h96, 1'b0, 0, 1'b0);
      model_errs++;
      total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL frm_fe: got %b want 1", fe); end
      total++; if (dv !== 1'b0) begin bad++; $display("[TB] FAIL frm_dv: got %b want 0", dv); end
      total++; if (ec !== 8'(model_errs)) begin bad++; $display("[TB] FAIL frm_ec: got %0d want %0d", ec, model_errs); end
      total++; if (pd !== last_good) begin bad++; $display("[TB] FAIL frm_pd: got %h want %h", pd, last_good); end
      busy_low = 0;
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b0);
         if (busy !== 1'b1) busy_low++;
      end
      total++; if (busy_low !== 0) begin bad++; $display("[TB] FAIL frm_wait_busy: got %0d idle cycles want 0", busy_low); end
      total++; if (fe_cnt - fe_before !== 1) begin bad++; $display("[TB] FAIL frm_fe_pulses: got %0d want 1", fe_cnt - fe_before); end
      send_bit(1'b1);
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL frm_recover_busy: got %b want 0", busy); end
      total++; if (dv_cnt - dv_before !== 0) begin bad++; $display("[TB] FAIL frm_dv_pulses: got %0d want 0", dv_cnt - dv_before); end
   endtask

   task automatic test_midframe_reset();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      rst = 1'b1;
      step();
      total++; if (pd !== 8'h00) begin bad++; $display("[TB] FAIL mrst_pd: got %h want 00", pd); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mrst_busy: got %b want 0", busy); end
      total++; if (ec !== 8'd0) begin bad++; $display("[TB] FAIL mrst_ec: got %0d want 0", ec); end
      total++; if (dv !== 1'b0 || fe !== 1'b0) begin bad++; $display("[TB] FAIL mrst_pulses: got dv=%b fe=%b want 0 0", dv, fe); end
      rst = 1'b0;
      model_errs = 0;
      last_good  = 8'h00;
      step();
      send_frame(8'h5A, 1'b1, 0, 1'b0);
      total++; if (dv !== 1'b1) begin bad++; $display("[TB] FAIL mrst_dv: got %b want 1", dv); end
      total++; if (pd !== 8'h5A) begin bad++; $display("[TB] FAIL mrst_data: got %h want 5a", pd); end
      last_good = 8'h5A;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         send_frame(8'($urandom), 1'b0, 0, 1'b0);
         model_errs++;
         send_bit(1'b1);
      end
      total++; if (ec_s !== 2'(sat(model_errs, 3))) begin bad++; $display("[TB] FAIL sat_ec2: got %0d want %0d", ec_s, sat(model_errs, 3)); end
      total++; if (ec !== 8'(sat(model_errs, 255))) begin bad++; $display("[TB] FAIL sat_ec8: got %0d want %0d", ec, sat(model_errs, 255)); end
      send_frame(8'($urandom), 1'b0, 0, 1'b1);
      model_errs = 0;
      total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL sat_clr_fe: got %b want 1", fe); end
      total++; if (ec_s !== 2'd0) begin bad++; $display("[TB] FAIL sat_clr_ec2: got %0d want 0", ec_s); end
      total++; if (ec !== 8'd0) begin bad++; $display("[TB] FAIL sat_clr_ec8: got %0d want 0", ec); end
      send_bit(1'b1);
   endtask

   task automatic test_random();
      int         exp_dv;
      int         dv_before;
      logic [7:0] d;
      logic       good;
      lsb_q.delete();
      msb_q.delete();
      dv_before = dv_cnt;
      exp_dv    = 0;
      for (int n = 0; n < 30; n++) begin
         d    = 8'($urandom);
         good = ($urandom_range(0, 99) < 75);
         repeat ($urandom_range(0, 2)) send_bit(1'b1);
         send_frame(d, good, 2, 1'b0);
         if (good) begin
            exp_dv++;
            last_good = d;
            total++; if (dv !== 1'b1 || pd !== d) begin bad++; $display("[TB] FAIL rnd_good %0d: got dv=%b pd=%h want 1 %h", n, dv, pd, d); end
            total++; if (pd_m !== rev8(d)) begin bad++; $display("[TB] FAIL rnd_msb %0d: got %h want %h", n, pd_m, rev8(d)); end
         end else begin
            model_errs++;
            total++; if (fe !== 1'b1 || dv !== 1'b0 || pd !== last_good) begin bad++; $display("[TB] FAIL rnd_bad %0d: got fe=%b dv=%b pd=%h want 1 0 %h", n, fe, dv, pd, last_good); end
            total++; if (ec !== 8'(sat(model_errs, 255)) || ec_s !== 2'(sat(model_errs, 3))) begin bad++; $display("[TB] FAIL rnd_ec %0d: got %0d/%0d want %0d/%0d", n, ec, ec_s, sat(model_errs, 255), sat(model_errs, 3)); end
            repeat ($urandom_range(0, 3)) send_bit(1'b0);
            send_bit(1'b1);
         end
         total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rnd_busy %0d: got %b want 0", n, busy); end
      end
      idle_cycle();
      total++; if (dv_cnt - dv_before !== exp_dv) begin bad++; $display("[TB] FAIL rnd_pulses: got %0d want %0d", dv_cnt - dv_before, exp_dv); end
   endtask

   // Scenario sequence followed by the one-line summary.
   initial begin
      rst      = 1'b1;
      in_bit   = 1'b1;
      in_valid = 1'b0;
      err_clr  = 1'b0;
      test_reset();
      test_basic();
      test_gapped();
      test_back_to_back();
      test_framing();
      test_midframe_reset();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
